mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register merged with the writeback selection logic. It sits directly downstream of the data-memory stage. It captures that stage's outputs (load word, ALU result, destination, control, PC+4, JAL flag) on each enabled clock. It then presents the final register-file write (data, index, enable) plus a retired-instruction counter. Sub-word load extraction (LB/LBU/LH/LHU/LW) happens here, ahead of the register.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
LINK_REG, 31, destination forced for JAL
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
stall_in  input  1  hold current WB contents
flush_in  input  1  insert bubble on this edge
valid_in  input  1  upstream slot holds a real instruction
read_data_in  input  32  word read from data memory
alu_result_in  input  32  ALU result / byte address
write_register_in  input  5  destination register
reg_write_in  input  1  register write request
mem_to_reg_in  input  1  1 = load data, 0 = ALU result
pc_plus_4_in  input  32  link value for JAL
is_jal_in  input  1  instruction is JAL
load_size_in  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
load_unsigned_in  input  1  zero-extend sub-word loads
wb_write_data_out  output  32  data to register file
wb_write_register_out  output  5  register file index
wb_reg_write_out  output  1  register file write enable
valid_out  output  1  WB slot holds a real instruction
misaligned_out  output  1  registered misaligned-load flag
retired_count_out  output  32  count of instructions committed

Behaviour:
- Reset (reset==0 at posedge) drives every output to 0: data, register, write enable, valid, misaligned, counter.
- Latency 1 cycle. All outputs are registered. No combinational path from inputs to outputs.
- Per-edge priority: reset > flush_in > stall_in > load.
- Flush: valid_out=0, wb_reg_write_out=0, misaligned_out=0. Data and register outputs are cleared to 0. Counter is unchanged.
- Stall (no flush): all outputs hold. Counter holds.
- Load: captures the computed values below.
- Load extraction, with addr = alu_result_in[1:0] and little-endian lanes:
  - Byte: lane = addr. Sign-extend bit 7 of the lane, or zero-extend if load_unsigned_in.
  - Half: lane = addr[1] (low half at addr[1]==0). Sign- or zero-extend bit 15.
  - Half with addr[0]==1: misaligned.
  - Word with addr != 0: misaligned.
- Writeback mux: is_jal_in selects pc_plus_4_in. Otherwise mem_to_reg_in selects the extracted load data. Otherwise alu_result_in.
- Destination: LINK_REG when is_jal_in, else write_register_in.
- Write enable = valid_in & (reg_write_in | is_jal_in) & (dest != 0) & ~misaligned.
- misaligned applies only when mem_to_reg_in=1.
- When misaligned: misaligned_out=1 for one captured slot, write suppressed, valid_out still 1.
- valid_in=0 on load: valid_out=0 and write enable 0. Data fields are still captured.
- Counter: increments by 1 on a load edge with valid_in=1 and not misaligned. Saturates at all-ones, no wrap.
- reset low while stalled or flushed: reset wins; all outputs are 0 on that edge.
- Same destination in back-to-back instructions: the newer value simply replaces the older. No interlock is performed here.

Decomposition:
- Shared package (mips_pkg.vh) holds:
  - LOAD_BYTE/LOAD_HALF/LOAD_WORD encodings
  - LINK_REG constant
  - reset-active level macro
- One combinational sub-module, load_extract (read_data, addr[1:0], size, unsigned -> data, misaligned). It is reusable by a future cache.
- The register, mux, and counter stay in mem_wb_stage.

Test Plan:
- Reset low two cycles, then high with valid LW: read_data=0x12345678, addr=0x10, rd=8, mem_to_reg=1 -> next edge wb data 0x12345678, reg 8, we=1, count=1.
- LB, addr=0x13, read_data=0x80FF00AA, signed -> 0xFFFFFF80. Same with LBU -> 0x00000080. Also LH at addr=0x12 -> 0xFFFF80FF.
- JAL, pc_plus_4=0x00400024, write_register_in=0 -> data 0x00400024, reg 31, we=1.
- LW addr=0x11 -> misaligned_out=1, we=0, valid_out=1, count unchanged. ADD with rd=0 -> we=0, count increments.
- stall_in=1 for 3 cycles with changing inputs -> outputs and count frozen. Then flush_in=1 with stall_in=1 -> valid_out=0, we=0.
- Preload counter to 0xFFFFFFFE via 2^32-2 retirements (force/backdoor), retire 3 more -> count stays 0xFFFFFFFF. Assert reset mid-stall -> all outputs 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load-size encodings, the link register
// index, the reset level and the alignment rule shared by any load-data consumer.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    LOAD_BYTE = 2'b00,
    LOAD_HALF = 2'b01,
    LOAD_WORD = 2'b10,
    LOAD_RSVD = 2'b11
  } load_size_e;

  localparam int   LINK_REG_IDX = 31;
  localparam logic RESET_ACTIVE = 1'b0;

  // The reserved encoding is handled exactly like a word access.
  function automatic logic is_misaligned(input load_size_e size, input logic [1:0] addr);
    logic mis;
    case (size)
      LOAD_BYTE: mis = 1'b0;
      LOAD_HALF: mis = addr[0];
      default:   mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Combinational little-endian sub-word load extraction with sign/zero extension
// and alignment detection; kept standalone so a cache front end can reuse it.
module load_extract
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [1:0]        addr_i,
  input  load_size_e        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = read_data_i[8*gi +: 8];
  end

  always_comb begin
    byte_lane = lanes[addr_i];
    half_lane = addr_i[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
    case (size_i)
      LOAD_BYTE: data_o = {{(DATA_W-8){byte_lane[7] & ~unsigned_i}}, byte_lane};
      LOAD_HALF: data_o = {{(DATA_W-16){half_lane[15] & ~unsigned_i}}, half_lane};
      default:   data_o = read_data_i;
    endcase
    misaligned_o = is_misaligned(size_i, addr_i);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback source selection, write-enable
// qualification and a saturating retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = LINK_REG_IDX,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_register_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [DATA_W-1:0]     pc_plus_4_in,
  input  logic                  is_jal_in,
  input  logic [1:0]            load_size_in,
  input  logic                  load_unsigned_in,
  output logic [DATA_W-1:0]     wb_write_data_out,
  output logic [REG_ADDR_W-1:0] wb_write_register_out,
  output logic                  wb_reg_write_out,
  output logic                  valid_out,
  output logic                  misaligned_out,
  output logic [CNT_W-1:0]      retired_count_out
);

  localparam logic [REG_ADDR_W-1:0] LINK_IDX = REG_ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]     load_data;
  logic                  load_mis;

  logic [DATA_W-1:0]     data_d, data_q;
  logic [REG_ADDR_W-1:0] dest_d, dest_q;
  logic                  we_d, we_q;
  logic                  valid_q;
  logic                  mis_d, mis_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .read_data_i  (read_data_in),
    .addr_i       (alu_result_in[1:0]),
    .size_i       (load_size_e'(load_size_in)),
    .unsigned_i   (load_unsigned_in),
    .data_o       (load_data),
    .misaligned_o (load_mis)
  );

  always_comb begin
    // Alignment only matters for real loads; a bubble never reports a fault.
    mis_d  = valid_in & mem_to_reg_in & load_mis;
    dest_d = is_jal_in ? LINK_IDX : write_register_in;
    if (is_jal_in)          data_d = pc_plus_4_in;
    else if (mem_to_reg_in) data_d = load_data;
    else                    data_d = alu_result_in;
    we_d  = valid_in & (reg_write_in | is_jal_in) & (dest_d != '0) & ~mis_d;
    cnt_d = cnt_q;
    if (valid_in && !mis_d && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      data_q  <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (flush_in) begin
      data_q  <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!stall_in) begin
      data_q  <= data_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      valid_q <= valid_in;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_write_data_out     = data_q;
  assign wb_write_register_out = dest_q;
  assign wb_reg_write_out      = we_q;
  assign valid_out             = valid_q;
  assign misaligned_out        = mis_q;
  assign retired_count_out     = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: the driver pushes hand-computed
// expectations per edge, a negedge monitor pops and compares them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, valid_in;
  logic [31:0] read_data_in, alu_result_in, pc_plus_4_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in, mem_to_reg_in, is_jal_in, load_unsigned_in;
  logic [1:0]  load_size_in;

  logic [31:0] wb_write_data_out, retired_count_out;
  logic [4:0]  wb_write_register_out;
  logic        wb_reg_write_out, valid_out, misaligned_out;

  logic [31:0] sat_data;
  logic [4:0]  sat_reg;
  logic        sat_we, sat_vld, sat_mis;
  logic [1:0]  sat_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .pc_plus_4_in(pc_plus_4_in), .is_jal_in(is_jal_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .wb_write_data_out(wb_write_data_out), .wb_write_register_out(wb_write_register_out),
    .wb_reg_write_out(wb_reg_write_out), .valid_out(valid_out),
    .misaligned_out(misaligned_out), .retired_count_out(retired_count_out)
  );

  // Narrow-counter copy so saturation is reachable in a few retirements.
  mem_wb_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .pc_plus_4_in(pc_plus_4_in), .is_jal_in(is_jal_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .wb_write_data_out(sat_data), .wb_write_register_out(sat_reg),
    .wb_reg_write_out(sat_we), .valid_out(sat_vld),
    .misaligned_out(sat_mis), .retired_count_out(sat_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we, vld, mis;
    logic [31:0] cnt;
    logic [1:0]  cnt_sat;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string field, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%h expected=%h", nm, field, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.name, "data",     wb_write_data_out,             mon_e.data);
      chk(mon_e.name, "reg",      32'(wb_write_register_out),    32'(mon_e.rd));
      chk(mon_e.name, "we",       32'(wb_reg_write_out),         32'(mon_e.we));
      chk(mon_e.name, "valid",    32'(valid_out),                32'(mon_e.vld));
      chk(mon_e.name, "mis",      32'(misaligned_out),           32'(mon_e.mis));
      chk(mon_e.name, "count",    retired_count_out,             mon_e.cnt);
      chk(mon_e.name, "sat_data", sat_data,                      mon_e.data);
      chk(mon_e.name, "sat_reg",  32'(sat_reg),                  32'(mon_e.rd));
      chk(mon_e.name, "sat_flags", 32'({sat_we, sat_vld, sat_mis}),
          32'({mon_e.we, mon_e.vld, mon_e.mis}));
      chk(mon_e.name, "sat_count", 32'(sat_cnt),                 32'(mon_e.cnt_sat));
      $display("txn %-10s data=%h reg=%0d we=%b v=%b mis=%b cnt=%0d sat=%0d",
               mon_e.name, wb_write_data_out, wb_write_register_out, wb_reg_write_out,
               valid_out, misaligned_out, retired_count_out, sat_cnt);
    end
  end

  task automatic drive(input logic rst_n, input logic stl, input logic fl, input logic vld,
                       input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic [31:0] pc4,
                       input logic jal, input logic [1:0] sz, input logic uns);
    reset = rst_n; stall_in = stl; flush_in = fl; valid_in = vld;
    read_data_in = rdata; alu_result_in = alu; write_register_in = rd;
    reg_write_in = rw; mem_to_reg_in = m2r; pc_plus_4_in = pc4;
    is_jal_in = jal; load_size_in = sz; load_unsigned_in = uns;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] data, input logic [4:0] rd,
                            input logic we, input logic vld, input logic mis,
                            input logic [31:0] cnt, input logic [1:0] cnt_sat);
    exp_t e;
    e.name = nm; e.data = data; e.rd = rd; e.we = we; e.vld = vld; e.mis = mis;
    e.cnt = cnt; e.cnt_sat = cnt_sat; e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 2'b10, 0);
    tick();
    //    rst stl fl vld rdata          alu            rd  rw m2r pc4           jal sz     uns
    drive(0, 0, 0, 1, 32'hFFFFFFFF, 32'h00000004, 5'd7, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("rst0", 32'h0, 5'd0, 0, 0, 0, 32'd0, 2'd0); tick();
    drive(0, 1, 1, 1, 32'hFFFFFFFF, 32'h00000004, 5'd7, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("rst1", 32'h0, 5'd0, 0, 0, 0, 32'd0, 2'd0); tick();
    drive(1, 0, 0, 1, 32'h12345678, 32'h00000010, 5'd8, 1, 1, 32'h0,        0, 2'b10, 0);
    expect_out("lw", 32'h12345678, 5'd8, 1, 1, 0, 32'd1, 2'd1); tick();
    drive(1, 0, 0, 1, 32'h80FF00AA, 32'h00000013, 5'd9, 1, 1, 32'h0,        0, 2'b00, 0);
    expect_out("lb", 32'hFFFFFF80, 5'd9, 1, 1, 0, 32'd2, 2'd2); tick();
    drive(1, 0, 0, 1, 32'h80FF00AA, 32'h00000013, 5'd9, 1, 1, 32'h0,        0, 2'b00, 1);
    expect_out("lbu", 32'h00000080, 5'd9, 1, 1, 0, 32'd3, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h80FF00AA, 32'h00000012, 5'd10, 1, 1, 32'h0,       0, 2'b01, 0);
    expect_out("lh", 32'hFFFF80FF, 5'd10, 1, 1, 0, 32'd4, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h11111111, 32'h00000100, 5'd0, 0, 0, 32'h00400024, 1, 2'b10, 0);
    expect_out("jal", 32'h00400024, 5'd31, 1, 1, 0, 32'd5, 2'd3); tick();
    drive(1, 0, 0, 1, 32'hDEADBEEF, 32'h00000011, 5'd8, 1, 1, 32'h0,        0, 2'b10, 0);
    expect_out("lw_mis", 32'hDEADBEEF, 5'd8, 0, 1, 1, 32'd5, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h0,        32'h00000007, 5'd0, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("add_r0", 32'h00000007, 5'd0, 0, 1, 0, 32'd6, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h80FF00AA, 32'h00000012, 5'd11, 1, 1, 32'h0,       0, 2'b01, 1);
    expect_out("lhu", 32'h000080FF, 5'd11, 1, 1, 0, 32'd7, 2'd3); tick();
    drive(1, 0, 0, 1, 32'hCAFEF00D, 32'h00000040, 5'd16, 1, 1, 32'h0,       0, 2'b11, 0);
    expect_out("rsvd_sz", 32'hCAFEF00D, 5'd16, 1, 1, 0, 32'd8, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h0000007F, 32'h00000020, 5'd12, 1, 1, 32'h0,       0, 2'b00, 0);
    expect_out("lb_pos", 32'h0000007F, 5'd12, 1, 1, 0, 32'd9, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h12345678, 32'h00000021, 5'd13, 1, 1, 32'h0,       0, 2'b01, 0);
    expect_out("lh_mis", 32'h00005678, 5'd13, 0, 1, 1, 32'd9, 2'd3); tick();
    drive(1, 0, 0, 0, 32'h0,        32'hAAAA5555, 5'd14, 1, 0, 32'h0,       0, 2'b10, 0);
    expect_out("bubble", 32'hAAAA5555, 5'd14, 0, 0, 0, 32'd9, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h0,        32'h00000003, 5'd15, 1, 0, 32'h0,       0, 2'b10, 0);
    expect_out("alu_odd", 32'h00000003, 5'd15, 1, 1, 0, 32'd10, 2'd3); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 32'h0BAD0000 + 32'(i), 32'h00000050, 5'd20 + 5'(i), 1, 1,
            32'h0, 0, 2'b10, 0);
      expect_out("stall", 32'h00000003, 5'd15, 1, 1, 0, 32'd10, 2'd3); tick();
    end
    drive(1, 1, 1, 1, 32'h0BAD0000, 32'h00000050, 5'd21, 1, 1, 32'h0,       0, 2'b10, 0);
    expect_out("flush", 32'h0, 5'd0, 0, 0, 0, 32'd10, 2'd3); tick();
    drive(1, 0, 0, 1, 32'h0,        32'h00000055, 5'd5, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("add_r5", 32'h00000055, 5'd5, 1, 1, 0, 32'd11, 2'd3); tick();
    drive(0, 1, 0, 1, 32'h0,        32'h00000066, 5'd6, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("rst_stall", 32'h0, 5'd0, 0, 0, 0, 32'd0, 2'd0); tick();
    drive(1, 0, 0, 1, 32'h0,        32'h00000001, 5'd3, 1, 0, 32'h0,        0, 2'b10, 0);
    expect_out("add_r3", 32'h00000001, 5'd3, 1, 1, 0, 32'd1, 2'd1); tick();
    drive(1, 0, 1, 1, 32'h0,        32'h00000001, 5'd0, 0, 0, 32'h00400100, 1, 2'b10, 0);
    expect_out("jal_flush", 32'h0, 5'd0, 0, 0, 0, 32'd1, 2'd1); tick();
    drive(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 2'b10, 0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
